ws2812_frame_ctrl: RTL and testbench

WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_scale.sv | 11 +
 rtl/ws2812_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding and timing constants for the WS2812 frame controller
package ws2812_pkg;

    localparam int BITS_PER_PIXEL      = 24;
    localparam int PHASES_PER_BIT      = 3;
    localparam int SLOT_CYCLES_DEFAULT = BITS_PER_PIXEL * PHASES_PER_BIT;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        DRAIN,
        GAP
    } state_t;

endpackage

// File: rtl/ws2812_scale.sv
// ws2812_scale: scales one colour channel by (brightness+1)/256, truncated
module ws2812_scale (
    input  logic [7:0] c,
    input  logic [7:0] brightness,
    output logic [7:0] out
);

    // 16-bit product; the top byte is the scaled channel, so 255 is identity and 0 blanks
    always_comb out = 8'(({8'd0, c} * ({8'd0, brightness} + 16'd1)) >> 8);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: fetches, scales and hands pixels to a WS2812 bit driver, one slot per pixel
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int GAP_CYCLES  = 8,
    parameter int SLOT_CYCLES = SLOT_CYCLES_DEFAULT
) (
    input  logic        clk_400k,
    input  logic        rst_n,
    input  logic        frame_req,
    input  logic [7:0]  num_leds,
    input  logic [7:0]  brightness,
    output logic [7:0]  pix_addr,
    output logic        pix_rd,
    input  logic [23:0] pix_data,
    output logic        drv_start,
    output logic        drv_has_next,
    output logic [7:0]  drv_r,
    output logic [7:0]  drv_g,
    output logic [7:0]  drv_b,
    input  logic        drv_busy,
    output logic        frame_busy,
    output logic        frame_done
);

    // pix_rd is registered one count early so it is visible at SLOT_CYCLES-3
    localparam logic [7:0] RD_AT   = 8'(SLOT_CYCLES - 4);
    localparam logic [7:0] CAP_AT  = 8'(SLOT_CYCLES - 2);
    localparam logic [7:0] END_AT  = 8'(SLOT_CYCLES - 1);
    localparam logic [7:0] DONE_AT = 8'(GAP_CYCLES - 2);
    localparam logic [7:0] GAP_END = 8'(GAP_CYCLES - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n, idx, idx_n, n_q, n_n, br_q, br_n, addr_n;
    logic [23:0] hold_q, hold_n, col_q, col_n, scaled;
    logic        first_q, first_n, rd_n, start_n, next_n, busy_n, done_n, more;

    ws2812_scale u_scale_r (.c(pix_data[23:16]), .brightness(br_q), .out(scaled[23:16]));
    ws2812_scale u_scale_g (.c(pix_data[15:8]),  .brightness(br_q), .out(scaled[15:8]));
    ws2812_scale u_scale_b (.c(pix_data[7:0]),   .brightness(br_q), .out(scaled[7:0]));

    // the first pixel of a frame arrives in its own drv_start cycle, so it bypasses col_q once
    assign {drv_r, drv_g, drv_b} = first_q ? scaled : col_q;
    assign more = (idx + 8'd1) < n_q;

    // next-state and next-output decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        n_n     = n_q;
        br_n    = br_q;
        hold_n  = hold_q;
        col_n   = col_q;
        first_n = 1'b0;
        addr_n  = pix_addr;
        rd_n    = 1'b0;
        start_n = 1'b0;
        next_n  = drv_has_next;
        busy_n  = frame_busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (frame_req && !drv_busy && !frame_busy) begin
                    n_n    = num_leds;
                    br_n   = brightness;
                    busy_n = 1'b1;
                    done_n = num_leds == 8'd0;
                    if (num_leds != 8'd0) begin
                        state_n = FETCH;
                        rd_n    = 1'b1;
                        addr_n  = 8'd0;
                    end
                end
            end
            FETCH: begin
                state_n = SEND;
                cnt_n   = 8'd0;
                idx_n   = 8'd0;
                start_n = 1'b1;
                next_n  = 1'b0;
                first_n = 1'b1;
            end
            SEND: begin
                cnt_n = cnt + 8'd1;
                if (first_q) col_n = scaled;
                if (cnt == RD_AT && more) begin
                    rd_n   = 1'b1;
                    addr_n = idx + 8'd1;
                end
                if (cnt == CAP_AT) hold_n = scaled;
                if (cnt == END_AT) begin
                    cnt_n = 8'd0;
                    if (more) begin
                        col_n   = hold_q;
                        start_n = 1'b1;
                        next_n  = 1'b1;
                        idx_n   = idx + 8'd1;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt < 8'd2) begin
                    cnt_n = cnt + 8'd1;
                end else if (!drv_busy) begin
                    state_n = GAP;
                    cnt_n   = 8'd0;
                end
            end
            GAP: begin
                cnt_n  = cnt + 8'd1;
                done_n = cnt == DONE_AT;
                if (cnt == GAP_END) begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; reset clears everything the driver can see
    always_ff @(posedge clk_400k or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            idx          <= 8'd0;
            n_q          <= 8'd0;
            br_q         <= 8'd0;
            hold_q       <= 24'd0;
            col_q        <= 24'd0;
            first_q      <= 1'b0;
            pix_addr     <= 8'd0;
            pix_rd       <= 1'b0;
            drv_start    <= 1'b0;
            drv_has_next <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            n_q          <= n_n;
            br_q         <= br_n;
            hold_q       <= hold_n;
            col_q        <= col_n;
            first_q      <= first_n;
            pix_addr     <= addr_n;
            pix_rd       <= rd_n;
            drv_start    <= start_n;
            drv_has_next <= next_n;
            frame_busy   <= busy_n;
            frame_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: table-driven frames plus reset, re-request and drain-timing sequences
module tb_ws2812_frame_ctrl;

    localparam int SLOT = 72;

    logic        clk_400k, rst_n, frame_req, pix_rd, drv_start, drv_has_next, drv_busy;
    logic        frame_busy, frame_done;
    logic [7:0]  num_leds, brightness, pix_addr, drv_r, drv_g, drv_b;
    logic [23:0] pix_data;

    ws2812_frame_ctrl #(.GAP_CYCLES(8), .SLOT_CYCLES(SLOT)) dut (
        .clk_400k(clk_400k), .rst_n(rst_n), .frame_req(frame_req), .num_leds(num_leds),
        .brightness(brightness), .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_data(pix_data),
        .drv_start(drv_start), .drv_has_next(drv_has_next), .drv_r(drv_r), .drv_g(drv_g),
        .drv_b(drv_b), .drv_busy(drv_busy), .frame_busy(frame_busy), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [7:0]       n;
        logic [7:0]       br;
        logic [2:0][23:0] pix;
        logic [2:0][23:0] exp;
    } vec_t;

    int errors = 0, checks = 0, cyc = 0, busy_left = 0, tail = 2;
    int rd_cnt, done_cnt, done_cyc, max_addr, fall_cyc;
    int start_cyc[$];
    int start_col[$];
    int start_nx[$];
    logic [23:0] mem [256];
    logic        prev_ok = 1'b0, prev_busy = 1'b0;
    logic [23:0] prev_col = 24'd0;
    vec_t        tv [6];

    initial begin
        clk_400k = 1'b0;
        forever #5 clk_400k = ~clk_400k;
    end

    // cycle counter, pixel buffer with one-cycle read latency, and a driver whose busy outlives each slot by tail
    initial begin
        pix_data = 24'd0;
        forever begin
            @(posedge clk_400k);
            cyc <= cyc + 1;
            pix_data <= pix_rd ? mem[pix_addr] : 24'h5A5A5A;
            busy_left <= drv_start ? SLOT + tail : (busy_left > 0 ? busy_left - 1 : 0);
        end
    end
    assign drv_busy = busy_left != 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // output monitor: logs driver loads, reads and frame ends; checks colour stays put between loads
    initial forever begin
        @(negedge clk_400k);
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (drv_start) begin
                start_cyc.push_back(cyc);
                start_col.push_back(int'({drv_r, drv_g, drv_b}));
                start_nx.push_back(int'(drv_has_next));
            end else if (prev_ok) begin
                chk("drv_stable", int'({drv_r, drv_g, drv_b}), int'(prev_col));
            end
            prev_col = {drv_r, drv_g, drv_b};
            prev_ok  = 1'b1;
            if (pix_rd) begin
                rd_cnt++;
                if (int'(pix_addr) > max_addr) max_addr = int'(pix_addr);
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", int'(frame_busy), 1);
            end
            if (prev_busy && !drv_busy) fall_cyc = cyc;
            prev_busy = drv_busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] n, input logic [7:0] br,
                                input logic [23:0] p0, p1, p2, e0, e1, e2);
        vec_t v;
        v.n = n; v.br = br;
        v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        return v;
    endfunction

    task automatic clear_mon();
        start_cyc.delete(); start_col.delete(); start_nx.delete();
        rd_cnt = 0; done_cnt = 0; done_cyc = -1; max_addr = -1; fall_cyc = -1;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (done_cnt == 0 && k < lim) begin
            @(negedge clk_400k);
            k++;
        end
        if (done_cnt == 0) begin
            errors++; checks++;
            $display("FAIL done_timeout: got no frame_done expected one within %0d cycles", lim);
        end
    endtask

    task automatic run_frame(input vec_t v, input int extra_req);
        int rc, exp_done, tl;
        for (int j = 0; j < 3; j++) mem[j] = v.pix[j];
        clear_mon();
        @(negedge clk_400k);
        frame_req = 1'b1; num_leds = v.n; brightness = v.br; rc = cyc;
        @(negedge clk_400k);
        frame_req = 1'b0;
        chk("busy_rise", int'(frame_busy), 1);
        if (extra_req > 0) begin
            repeat (extra_req) @(negedge clk_400k);
            frame_req = 1'b1; num_leds = 8'd3;
            @(negedge clk_400k);
            frame_req = 1'b0;
        end
        wait_done(1000);
        repeat (3) @(negedge clk_400k);
        chk("done_count", done_cnt, 1);
        chk("starts", start_cyc.size(), int'(v.n));
        chk("rd_count", rd_cnt, int'(v.n));
        chk("busy_idle", int'(frame_busy), 0);
        if (v.n == 8'd0) begin
            chk("zero_done_t", done_cyc - rc, 1);
        end else begin
            chk("max_addr", max_addr, int'(v.n) - 1);
            tl = 2 + SLOT * (int'(v.n) - 1);
            exp_done = tl + ((73 + tail) > 74 ? 73 + tail : 74) + 8;
            chk("done_t", done_cyc - rc, exp_done);
        end
        for (int i = 0; i < start_cyc.size() && i < int'(v.n); i++) begin
            chk("start_t", start_cyc[i] - rc, 2 + SLOT * i);
            chk("has_next", start_nx[i], int'(i != 0));
            chk("colour", start_col[i], int'(v.exp[i]));
        end
    endtask

    initial begin
        rst_n = 1'b1; frame_req = 1'b0; num_leds = 8'd0; brightness = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 24'd0;
        clear_mon();
        tv[0] = mk(8'd3, 8'd255, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000, 24'h00FF00, 24'h0000FF);
        tv[1] = mk(8'd1, 8'd127, 24'h80C0FF, 24'h0,      24'h0,      24'h4060_7F, 24'h0,   24'h0);
        tv[2] = mk(8'd2, 8'd0,   24'hFFFFFF, 24'h123456, 24'h0,      24'h000000, 24'h000000, 24'h0);
        tv[3] = mk(8'd3, 8'h3F,  24'hFF8040, 24'h010203, 24'h7F7F7F, 24'h3F2010, 24'h000000, 24'h1F1F1F);
        tv[4] = mk(8'd2, 8'h80,  24'hFF1001, 24'h64C802, 24'h0,      24'h800800, 24'h326401, 24'h0);
        tv[5] = mk(8'd0, 8'd255, 24'hABCDEF, 24'h0,      24'h0,      24'h0,      24'h0,      24'h0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_400k);
        chk("rst_pix_rd", int'(pix_rd), 0);
        chk("rst_pix_addr", int'(pix_addr), 0);
        chk("rst_drv_start", int'(drv_start), 0);
        chk("rst_rgb", int'({drv_r, drv_g, drv_b}), 0);
        chk("rst_busy", int'(frame_busy), 0);
        chk("rst_done", int'(frame_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_400k);

        for (int i = 0; i < 6; i++) run_frame(tv[i], 0);

        // repeated requests during SEND and DRAIN are dropped
        run_frame(mk(8'd2, 8'd255, 24'h112233, 24'h445566, 24'h0, 24'h112233, 24'h445566, 24'h0), 30);
        run_frame(mk(8'd1, 8'd255, 24'h0A0B0C, 24'h0, 24'h0, 24'h0A0B0C, 24'h0, 24'h0), 75);

        // driver stays busy 100 cycles past the last slot
        tail = 99;
        run_frame(tv[1], 0);
        chk("gap_after_busy", done_cyc - fall_cyc, 8);

        // driver already idle before the slot ends: busy ignored for two drain cycles
        tail = -3;
        run_frame(tv[1], 0);
        tail = 2;

        // reset during the second pixel of a frame
        for (int j = 0; j < 3; j++) mem[j] = tv[0].pix[j];
        clear_mon();
        @(negedge clk_400k);
        frame_req = 1'b1; num_leds = 8'd3; brightness = 8'd255;
        @(negedge clk_400k);
        frame_req = 1'b0;
        repeat (112) @(negedge clk_400k);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pix_rd", int'(pix_rd), 0);
        chk("ar_pix_addr", int'(pix_addr), 0);
        chk("ar_has_next", int'(drv_has_next), 0);
        chk("ar_rgb", int'({drv_r, drv_g, drv_b}), 0);
        chk("ar_busy", int'(frame_busy), 0);
        chk("ar_start", int'(drv_start), 0);
        @(negedge clk_400k);
        rst_n = 1'b1;
        clear_mon();
        frame_req = 1'b1; num_leds = 8'd1;
        @(negedge clk_400k);
        frame_req = 1'b0;
        repeat (2) @(negedge clk_400k);
        chk("req_while_drv_busy_busy", int'(frame_busy), 0);
        chk("req_while_drv_busy_rd", rd_cnt, 0);
        for (int k = 0; k < 200 && drv_busy; k++) @(negedge clk_400k);
        run_frame(tv[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
